pmem_scheduler: RTL and testbench

Cacheline-granularity scheduler placed between the L1 caches and the single cacheline adaptor port to physical memory. It serves three requesters: I-cache miss fills, D-cache fills and writebacks, and a next-line instruction prefetcher. It issues one line transaction at a time and uses fixed priority with aging-based starvation override. A prefetch that targets the same line as a concurrent I-cache miss is coalesced into that miss, so both requesters complete from a single memory transaction.

---
 rtl/pmem_scheduler_if.sv | 37 +++
 rtl/pmem_scheduler.sv | 103 ++++++++++
 tb/tb_pmem_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_scheduler_if.sv
// Bundle of the three L1 requester ports and the cacheline adaptor port.
// slave is the scheduler's view; master is the requesters plus adaptor side.
interface pmem_scheduler_if #(parameter int LW = 256);
    logic          i_read;
    logic [31:0]   i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          p_read;
    logic [31:0]   p_address;
    logic [LW-1:0] p_rdata;
    logic          p_resp;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               p_read, p_address, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               p_read, p_address, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/pmem_scheduler.sv
// One-line-at-a-time scheduler for I-fill, D-fill/writeback and prefetch,
// fixed priority D > I > P with aging override and I/P same-line coalescing.
module pmem_scheduler #(
    parameter int s_offset     = 5,
    parameter int STARVE_LIMIT = 8
) (
    input logic             clk,
    input logic             reset_n,
    pmem_scheduler_if.slave bus
);
    localparam int LW = (2**s_offset) * 8;
    localparam int RD = 0;
    localparam int RI = 1;
    localparam int RP = 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [2:0]      req, starved, win, gnt;
    logic [2:0][3:0] age, age_nx;
    logic            coal, coal_nx, op_wr;
    logic [31:0]     sel_addr, addr;
    logic [LW-1:0]   wdata, line;

    function automatic logic [2:0] pick(input logic [2:0] v);
        if (v[RD]) return 3'b001;
        if (v[RI]) return 3'b010;
        if (v[RP]) return 3'b100;
        return 3'b000;
    endfunction

    assign req = {bus.p_read, bus.i_read, bus.d_read | bus.d_write};

    always_comb begin
        starved = '0;
        for (int k = 0; k < 3; k++)
            starved[k] = req[k] && (age[k] >= 4'(STARVE_LIMIT));
        win = pick((|starved) ? starved : req);
        sel_addr = win[RD] ? bus.d_address : (win[RI] ? bus.i_address : bus.p_address);
        coal_nx = win[RI] && bus.p_read &&
                  ((bus.i_address & LINE_MASK) == (bus.p_address & LINE_MASK));
    end

    // Losers age (saturating), winners and idle requesters restart from zero.
    always_comb begin
        age_nx = '0;
        for (int k = 0; k < 3; k++) begin
            if (!req[k] || win[k])    age_nx[k] = 4'd0;
            else if (age[k] != 4'hf)  age_nx[k] = age[k] + 4'd1;
            else                      age_nx[k] = age[k];
        end
        if (coal_nx) age_nx[RP] = 4'd0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = BUSY;
            BUSY:    if (bus.mem_resp) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt   <= '0;
            coal  <= 1'b0;
            op_wr <= 1'b0;
            age   <= '0;
            addr  <= '0;
            wdata <= '0;
            line  <= '0;
        end else begin
            if (state == IDLE && |req) begin
                gnt   <= win;
                coal  <= coal_nx;
                age   <= age_nx;
                op_wr <= win[RD] & bus.d_write;
                addr  <= sel_addr & LINE_MASK;
                wdata <= bus.d_wdata;
            end
            if (state == BUSY && bus.mem_resp) line <= bus.mem_rdata;
        end
    end

    assign bus.mem_read    = (state == BUSY) && !op_wr;
    assign bus.mem_write   = (state == BUSY) && op_wr;
    assign bus.mem_address = addr;
    assign bus.mem_wdata   = wdata;
    assign bus.i_resp      = (state == DONE) && gnt[RI];
    assign bus.d_resp      = (state == DONE) && gnt[RD];
    assign bus.p_resp      = (state == DONE) && (gnt[RP] || coal);
    assign bus.i_rdata     = line;
    assign bus.d_rdata     = line;
    assign bus.p_rdata     = line;
endmodule

// File: tb/tb_pmem_scheduler.sv
// Randomized and directed bench for pmem_scheduler against a transaction-level
// model of arbitration, aging and coalescing.
module tb_pmem_scheduler;
    logic clk;
    logic reset_n;
    pmem_scheduler_if #(.LW(256)) bus();

    pmem_scheduler #(.s_offset(5), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: index 0 = D, 1 = I, 2 = P.
    int          age[3];
    bit          pend[3];
    logic [31:0] paddr[3];
    bit          dwr;
    logic [255:0] dwd;
    int          rd_cycles;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reqs();
        bus.d_read    = pend[0] && !dwr;
        bus.d_write   = pend[0] && dwr;
        bus.d_address = paddr[0];
        bus.d_wdata   = dwd;
        bus.i_read    = pend[1];
        bus.i_address = paddr[1];
        bus.p_read    = pend[2];
        bus.p_address = paddr[2];
    endtask

    function automatic int pick_winner();
        int w = -1;
        for (int k = 0; k < 3; k++) if (w < 0 && pend[k] && age[k] >= 8) w = k;
        for (int k = 0; k < 3; k++) if (w < 0 && pend[k]) w = k;
        return w;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin pend[k] = 0; age[k] = 0; paddr[k] = '0; end
        dwr = 0; dwd = '0;
        apply_reqs();
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Runs one transaction starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic run_txn(input int wait_cyc, input bit drop, output int winner);
        int w;
        bit co;
        bit exp_rd;
        logic [31:0] ea;
        logic [255:0] rd;
        apply_reqs();
        w  = pick_winner();
        co = (w == 1) && pend[2] && (paddr[1][31:5] == paddr[2][31:5]);
        for (int k = 0; k < 3; k++) begin
            if (!pend[k] || k == w) age[k] = 0;
            else if (age[k] < 15)   age[k] = age[k] + 1;
        end
        if (co) age[2] = 0;
        ea = {paddr[w][31:5], 5'b0};
        exp_rd = !(w == 0 && dwr);
        rd = '0;
        for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
        rd_cycles = 0;
        tick();
        for (int c = 0; c <= wait_cyc; c++) begin
            chk("busy_mem_read", 256'(bus.mem_read), 256'(exp_rd));
            chk("busy_mem_write", 256'(bus.mem_write), 256'(!exp_rd));
            chk("busy_mem_address", 256'(bus.mem_address), 256'(ea));
            if (!exp_rd) chk("busy_mem_wdata", bus.mem_wdata, dwd);
            chk("busy_resp_quiet", 256'({bus.i_resp, bus.d_resp, bus.p_resp}), 256'(0));
            if (bus.mem_read) rd_cycles++;
            if (c == 0 && drop) begin pend[w] = 0; apply_reqs(); end
            if (c == wait_cyc) begin bus.mem_rdata = rd; bus.mem_resp = 1'b1; end
            tick();
            bus.mem_resp = 1'b0;
        end
        chk("done_mem_rw", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        chk("done_i_resp", 256'(bus.i_resp), 256'(w == 1));
        chk("done_d_resp", 256'(bus.d_resp), 256'(w == 0));
        chk("done_p_resp", 256'(bus.p_resp), 256'(w == 2 || co));
        if (w == 1) chk("done_i_rdata", bus.i_rdata, rd);
        if (w == 2 || co) chk("done_p_rdata", bus.p_rdata, rd);
        if (w == 0 && !dwr) chk("done_d_rdata", bus.d_rdata, rd);
        pend[w] = 0;
        if (co) pend[2] = 0;
        apply_reqs();
        winner = w;
        tick();
    endtask

    initial begin
        int w;
        int exp_seq[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
        bit seen[3];

        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin pend[k] = 0; age[k] = 0; paddr[k] = '0; end
        dwr = 0; dwd = '0;
        apply_reqs();
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("reset_mem_rw", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        chk("reset_resps", 256'({bus.i_resp, bus.d_resp, bus.p_resp}), 256'(0));
        chk("reset_mem_address", 256'(bus.mem_address), 256'(0));
        chk("reset_rdata", bus.i_rdata | bus.d_rdata | bus.p_rdata | bus.mem_wdata, 256'(0));
        do_reset();

        // Single I read with three mem_read cycles
        pend[1] = 1; paddr[1] = 32'h0000_1234;
        run_txn(2, 0, w);
        chk("single_winner", 256'(w), 256'(1));
        chk("single_rd_cycles", 256'(rd_cycles), 256'(3));

        // All three requesting continuously: aging override order
        do_reset();
        seen = '{0, 0, 0};
        for (int t = 0; t < 32; t++) begin
            pend = '{1, 1, 1};
            paddr[0] = 32'h0000_0400; paddr[1] = 32'h0000_0100; paddr[2] = 32'h0000_0200;
            dwr = 0;
            run_txn(0, 0, w);
            if (t < 10) chk("starve_seq", 256'(w), 256'(exp_seq[t]));
            seen[w] = 1;
        end
        for (int k = 0; k < 3; k++) chk("starve_served", 256'(seen[k]), 256'(1));
        pend = '{0, 0, 0};
        apply_reqs();

        // Coalesced I/P on the same line, then split on different lines
        do_reset();
        pend[1] = 1; paddr[1] = 32'h4000_0040;
        pend[2] = 1; paddr[2] = 32'h4000_0050;
        run_txn(1, 0, w);
        chk("coal_winner", 256'(w), 256'(1));
        tick();
        chk("coal_single_txn", 256'(bus.mem_read), 256'(0));
        pend[1] = 1; paddr[1] = 32'h4000_0040;
        pend[2] = 1; paddr[2] = 32'h4000_0060;
        run_txn(0, 0, w);
        chk("split_first", 256'(w), 256'(1));
        run_txn(0, 0, w);
        chk("split_second", 256'(w), 256'(2));

        // D writeback
        pend[0] = 1; paddr[0] = 32'h8000_0000; dwr = 1; dwd = {32{8'hA5}};
        run_txn(3, 0, w);
        chk("write_winner", 256'(w), 256'(0));
        dwr = 0;

        // Reset in the middle of BUSY
        pend[1] = 1; paddr[1] = 32'h0000_0300;
        apply_reqs();
        tick();
        chk("mid_busy_read", 256'(bus.mem_read), 256'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_mem_read", 256'(bus.mem_read), 256'(0));
        chk("mid_reset_address", 256'(bus.mem_address), 256'(0));
        chk("mid_reset_rdata", bus.i_rdata, 256'(0));
        pend[1] = 0;
        for (int k = 0; k < 3; k++) age[k] = 0;
        apply_reqs();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_reset_quiet", 256'({bus.i_resp, bus.d_resp, bus.p_resp, bus.mem_read}), 256'(0));
        end
        pend[1] = 1; paddr[1] = 32'h0000_0560;
        run_txn(1, 0, w);
        chk("post_reset_txn", 256'(w), 256'(1));

        // Spurious mem_resp while idle
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        chk("spurious_resp", 256'({bus.i_resp, bus.d_resp, bus.p_resp}), 256'(0));
        tick();
        chk("spurious_resp_late", 256'({bus.i_resp, bus.d_resp, bus.p_resp, bus.mem_read}), 256'(0));

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1;
                    paddr[k] = $urandom;
                    if (k == 0) begin
                        dwr = $urandom_range(0, 1) == 1;
                        for (int j = 0; j < 8; j++) dwd[j*32 +: 32] = $urandom;
                    end
                    if (k == 2 && pend[1] && $urandom_range(0, 2) == 0)
                        paddr[2] = {paddr[1][31:5], 5'($urandom)};
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin pend[1] = 1; paddr[1] = $urandom; end
            run_txn($urandom_range(0, 3), $urandom_range(0, 7) == 0, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
